// File: rtl/temp_monitor_ctl_if.sv
// Bundle for the ADC request/done handshake and the averaged-result strobe.
// Ports: conv_req/conv_ch (to ADC), conv_done/adc_data (from ADC),
//        avg_data/avg_ch/avg_valid (to slow-control register space).
interface temp_monitor_ctl_if #(
  parameter int NCH = 4,
  parameter int DW  = 10
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic          conv_req;
  logic [CW-1:0] conv_ch;
  logic          conv_done;
  logic [DW-1:0] adc_data;
  logic [DW-1:0] avg_data;
  logic [CW-1:0] avg_ch;
  logic          avg_valid;

  // master: the monitor controller; slave: ADC model / result consumer
  modport master (
    output conv_req, conv_ch, avg_data, avg_ch, avg_valid,
    input  conv_done, adc_data
  );

  modport slave (
    input  conv_req, conv_ch, avg_data, avg_ch, avg_valid,
    output conv_done, adc_data
  );
endinterface

// File: rtl/temp_monitor_ctl.sv
// Multi-channel temperature monitor: sequences ADC conversions per channel,
// averages 2^AVG_LOG2 samples, applies high/low hysteresis thresholds.
// Ports: clk, rst (sync, active-high), enable, thresh_hi/lo, sticky_clr,
//        bus (ADC handshake + average result), alarm, alarm_sticky, timeout_err.
// All outputs registered; the ADC may stall each conversion up to TIMEOUT cycles.
module temp_monitor_ctl #(
  parameter int NCH      = 4,
  parameter int DW       = 10,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [DW-1:0]       thresh_hi,
  input  logic [DW-1:0]       thresh_lo,
  input  logic                sticky_clr,
  temp_monitor_ctl_if.master  bus,
  output logic [NCH-1:0]      alarm,
  output logic [NCH-1:0]      alarm_sticky,
  output logic                timeout_err
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW = DW + AVG_LOG2;
  localparam int NW = AVG_LOG2 + 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [NW-1:0] LAST_N = NW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESULT} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  ch_q, ch_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [NW-1:0]  n_q, n_d;
  logic [TW-1:0]  wcnt_q, wcnt_d;
  logic           conv_req_q, conv_req_d;
  logic [CW-1:0]  conv_ch_q, conv_ch_d;
  logic [DW-1:0]  avg_data_q, avg_data_d;
  logic [CW-1:0]  avg_ch_q, avg_ch_d;
  logic           avg_valid_q, avg_valid_d;
  logic [NCH-1:0] alarm_q, alarm_d;
  logic [NCH-1:0] sticky_q, sticky_d;
  logic           toerr_q, toerr_d;

  logic [DW-1:0]  avg;
  logic [CW-1:0]  ch_adv;
  logic [NCH-1:0] ch_mask;
  logic [TW-1:0]  wcnt_inc;
  logic [NCH-1:0] sticky_set;
  logic           toerr_set;

  // Truncating divide by the sample count; acc is sized so it never overflows.
  assign avg      = acc_q[AW-1:AVG_LOG2];
  assign ch_adv   = (ch_q == CW'(NCH - 1)) ? '0 : ch_q + CW'(1);
  assign ch_mask  = NCH'(1) << ch_q;
  assign wcnt_inc = wcnt_q + TW'(1);

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    acc_d       = acc_q;
    n_d         = n_q;
    wcnt_d      = wcnt_q;
    conv_ch_d   = conv_ch_q;
    avg_data_d  = avg_data_q;
    avg_ch_d    = avg_ch_q;
    avg_valid_d = 1'b0;
    alarm_d     = alarm_q;
    sticky_set  = '0;
    toerr_set   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_REQ;
      end
      S_REQ: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.conv_done) begin
          acc_d   = acc_q + AW'(bus.adc_data);
          n_d     = n_q + NW'(1);
          state_d = (n_q == LAST_N) ? S_RESULT : S_REQ;
        end else if (wcnt_inc >= TW'(TIMEOUT)) begin
          // Abandon the channel: partial sum is dropped, alarm left as is.
          toerr_set = 1'b1;
          acc_d     = '0;
          n_d       = '0;
          wcnt_d    = '0;
          ch_d      = ch_adv;
          state_d   = S_IDLE;
        end else begin
          wcnt_d = wcnt_inc;
        end
      end
      S_RESULT: begin
        // Between the thresholds (inclusive) the alarm holds its state.
        if (avg > thresh_hi) begin
          alarm_d    = alarm_q | ch_mask;
          sticky_set = ch_mask;
        end else if (avg < thresh_lo) begin
          alarm_d = alarm_q & ~ch_mask;
        end
        avg_data_d  = avg;
        avg_ch_d    = ch_q;
        avg_valid_d = 1'b1;
        acc_d       = '0;
        n_d         = '0;
        ch_d        = ch_adv;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered request tracks the state register one-for-one.
    conv_req_d = (state_d == S_REQ);
    if (state_d == S_REQ) conv_ch_d = ch_d;

    // A set in the same cycle as a clear wins.
    sticky_d = (sticky_q & ~{NCH{sticky_clr}}) | sticky_set;
    toerr_d  = (toerr_q & ~sticky_clr) | toerr_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      acc_q       <= '0;
      n_q         <= '0;
      wcnt_q      <= '0;
      conv_req_q  <= 1'b0;
      conv_ch_q   <= '0;
      avg_data_q  <= '0;
      avg_ch_q    <= '0;
      avg_valid_q <= 1'b0;
      alarm_q     <= '0;
      sticky_q    <= '0;
      toerr_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      acc_q       <= acc_d;
      n_q         <= n_d;
      wcnt_q      <= wcnt_d;
      conv_req_q  <= conv_req_d;
      conv_ch_q   <= conv_ch_d;
      avg_data_q  <= avg_data_d;
      avg_ch_q    <= avg_ch_d;
      avg_valid_q <= avg_valid_d;
      alarm_q     <= alarm_d;
      sticky_q    <= sticky_d;
      toerr_q     <= toerr_d;
    end
  end

  assign bus.conv_req  = conv_req_q;
  assign bus.conv_ch   = conv_ch_q;
  assign bus.avg_data  = avg_data_q;
  assign bus.avg_ch    = avg_ch_q;
  assign bus.avg_valid = avg_valid_q;
  assign alarm         = alarm_q;
  assign alarm_sticky  = sticky_q;
  assign timeout_err   = toerr_q;

endmodule

// File: tb/tb_temp_monitor_ctl.sv
// Scoreboard bench for temp_monitor_ctl: expected requests and averages are
// queued as stimulus is issued; monitors pop and compare on conv_req/avg_valid.
module tb_temp_monitor_ctl;
  localparam int NCH = 4;
  localparam int DW = 10;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           enable;
  logic           sticky_clr;
  logic [DW-1:0]  thresh_hi, thresh_lo;
  logic [NCH-1:0] alarm, alarm_sticky;
  logic           timeout_err;
  logic           resp_done = 1'b0;
  logic           stray_done = 1'b0;
  logic [DW-1:0]  resp_data = '0;
  logic           pend = 1'b0;

  temp_monitor_ctl_if #(.NCH(NCH), .DW(DW)) bus ();

  assign bus.conv_done = resp_done | stray_done;
  assign bus.adc_data  = stray_done ? 10'd1000 : resp_data;

  temp_monitor_ctl #(.NCH(NCH), .DW(DW), .AVG_LOG2(2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .thresh_hi(thresh_hi), .thresh_lo(thresh_lo), .sticky_clr(sticky_clr),
    .bus(bus), .alarm(alarm), .alarm_sticky(alarm_sticky), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [DW-1:0]  data;
    logic [1:0]     ch;
    logic [NCH-1:0] alarm;
    logic [NCH-1:0] sticky;
  } avg_exp_t;

  logic [DW-1:0] samp_q[$];
  int            exp_req[$];
  avg_exp_t      exp_avg[$];
  avg_exp_t      mon_e;
  int tests = 0, fails = 0;
  int req_count = 0, nreq_pushed = 0, cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ADC model: answers each request one cycle later while samples are queued.
  always @(negedge clk) begin
    resp_done = 1'b0;
    if (pend && samp_q.size() > 0) begin
      resp_done = 1'b1;
      resp_data = samp_q.pop_front();
    end
    pend = bus.conv_req;
  end

  always @(negedge clk) begin
    if (bus.conv_req) begin
      req_count++;
      if (exp_req.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_req: got conv_req for ch %0d, expected none", bus.conv_ch);
      end else begin
        check("conv_ch", 32'(bus.conv_ch), 32'(exp_req.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (bus.avg_valid) begin
      if (exp_avg.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_avg: got avg_data %0d ch %0d, expected no avg_valid",
                 bus.avg_data, bus.avg_ch);
      end else begin
        mon_e = exp_avg.pop_front();
        check("avg_data", 32'(bus.avg_data), 32'(mon_e.data));
        check("avg_ch", 32'(bus.avg_ch), 32'(mon_e.ch));
        check("alarm", 32'(alarm), 32'(mon_e.alarm));
        check("alarm_sticky", 32'(alarm_sticky), 32'(mon_e.sticky));
      end
    end
  end

  task automatic push_chan(input int ch, input int s0, input int s1, input int s2, input int s3,
                           input int avg, input logic [NCH-1:0] al, input logic [NCH-1:0] st);
    avg_exp_t e;
    samp_q.push_back(DW'(s0)); samp_q.push_back(DW'(s1));
    samp_q.push_back(DW'(s2)); samp_q.push_back(DW'(s3));
    for (int i = 0; i < 4; i++) exp_req.push_back(ch);
    nreq_pushed += 4;
    e.data = DW'(avg); e.ch = 2'(ch); e.alarm = al; e.sticky = st;
    exp_avg.push_back(e);
  endtask

  // sel 0: conv_req, sel 1: avg_valid
  task automatic wait_high(input string name, input int sel);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((sel == 0 && bus.conv_req) || (sel == 1 && bus.avg_valid)) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL %s: got no strobe within 200 cycles, expected one", name);
    end
  endtask

  // Count requests up to the k-th of the current burst; optionally drop enable at the first.
  task automatic count_reqs(input string name, input int k);
    int n = 0;
    for (int i = 0; i < 200 && n < k; i++) begin
      @(negedge clk);
      if (bus.conv_req) begin
        n++;
        if (n == 1) enable = 1'b0;
      end
    end
    check(name, 32'(n), 32'(k));
  endtask

  // Scan until the k-th request of the last queued channel, then park and drain.
  task automatic run_scan(input int k);
    int target = nreq_pushed - 4 + k;
    enable = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (req_count >= target) break;
    end
    enable = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (exp_avg.size() == 0) break;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check("req_count_after_park", 32'(req_count), 32'(nreq_pushed));
    check("avg_queue_drained", 32'(exp_avg.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst = 1'b1; enable = 1'b0; sticky_clr = 1'b0;
    thresh_hi = 10'd1023; thresh_lo = 10'd0;
    repeat (2) @(negedge clk);
    check("rst_conv_req", 32'(bus.conv_req), 0);
    check("rst_conv_ch", 32'(bus.conv_ch), 0);
    check("rst_avg", 32'({bus.avg_data, bus.avg_ch, bus.avg_valid}), 0);
    check("rst_alarms", 32'({alarm, alarm_sticky, timeout_err}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Averaging, wrap 0..3..0, and ENABLE dropped in ch1's second sample.
    push_chan(0, 100, 101, 102, 103, 101, 4'b0000, 4'b0000);
    push_chan(1, 200, 200, 200, 204, 201, 4'b0000, 4'b0000);
    push_chan(2, 300, 301, 302, 303, 301, 4'b0000, 4'b0000);
    push_chan(3, 400, 0, 0, 0, 100, 4'b0000, 4'b0000);
    push_chan(0, 10, 20, 30, 40, 25, 4'b0000, 4'b0000);
    push_chan(1, 1, 2, 3, 5, 2, 4'b0000, 4'b0000);
    enable = 1'b1;
    wait_high("first_req", 0);
    t0 = cyc;
    wait_high("first_avg", 1);
    // avg_valid lands in the 10th cycle counting the CONV_REQ cycle as the first
    check("avg_latency", 32'(cyc - t0), 32'd9);
    run_scan(2);

    // Hysteresis on ch2 (ch3 driven into alarm and held there).
    thresh_hi = 10'd600; thresh_lo = 10'd550;
    push_chan(2, 610, 610, 610, 610, 610, 4'b0100, 4'b0100);
    push_chan(3, 700, 700, 700, 700, 700, 4'b1100, 4'b1100);
    push_chan(0, 0, 0, 0, 0, 0, 4'b1100, 4'b1100);
    push_chan(1, 0, 0, 0, 0, 0, 4'b1100, 4'b1100);
    push_chan(2, 580, 580, 580, 580, 580, 4'b1100, 4'b1100);
    push_chan(3, 560, 560, 560, 560, 560, 4'b1100, 4'b1100);
    push_chan(0, 0, 0, 0, 0, 0, 4'b1100, 4'b1100);
    push_chan(1, 0, 0, 0, 0, 0, 4'b1100, 4'b1100);
    push_chan(2, 600, 600, 600, 600, 600, 4'b1100, 4'b1100);
    push_chan(3, 560, 560, 560, 560, 560, 4'b1100, 4'b1100);
    push_chan(0, 0, 0, 0, 0, 0, 4'b1100, 4'b1100);
    push_chan(1, 0, 0, 0, 0, 0, 4'b1100, 4'b1100);
    push_chan(2, 540, 540, 540, 540, 540, 4'b1000, 4'b1100);
    run_scan(1);

    // Timeout on ch3: no samples queued, so the ADC never answers.
    exp_req.push_back(3); nreq_pushed++;
    enable = 1'b1;
    wait_high("timeout_req", 0);
    enable = 1'b0;
    repeat (TIMEOUT) @(negedge clk);
    check("timeout_err_early", 32'(timeout_err), 0);
    @(negedge clk);
    check("timeout_err", 32'(timeout_err), 1);
    repeat (5) @(negedge clk);
    check("alarm_after_timeout", 32'(alarm), 32'(4'b1000));

    // ch0 sets its alarm while STICKY_CLR is high in the RESULT cycle.
    push_chan(0, 800, 800, 800, 800, 800, 4'b1001, 4'b0001);
    enable = 1'b1;
    count_reqs("collision_reqs", 4);
    @(negedge clk);
    @(negedge clk);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    check("timeout_err_cleared", 32'(timeout_err), 0);
    check("sticky_after_collision", 32'(alarm_sticky), 32'(4'b0001));
    repeat (5) @(negedge clk);

    // Stray CONV_DONE in IDLE must not reach the accumulator.
    stray_done = 1'b1;
    repeat (2) @(negedge clk);
    stray_done = 1'b0;
    push_chan(1, 40, 41, 42, 43, 41, 4'b1001, 4'b0001);
    run_scan(1);

    // Reset in WAIT of ch2's third sample, with a coincident CONV_DONE.
    samp_q.push_back(10'd900); samp_q.push_back(10'd900);
    for (int i = 0; i < 3; i++) exp_req.push_back(2);
    nreq_pushed += 3;
    enable = 1'b1;
    count_reqs("pre_reset_reqs", 3);
    @(negedge clk);
    rst = 1'b1; stray_done = 1'b1;
    @(negedge clk);
    check("midrst_conv", 32'({bus.conv_req, bus.conv_ch}), 0);
    check("midrst_avg", 32'({bus.avg_data, bus.avg_ch, bus.avg_valid}), 0);
    check("midrst_alarms", 32'({alarm, alarm_sticky, timeout_err}), 0);
    rst = 1'b0; stray_done = 1'b0;
    repeat (2) @(negedge clk);
    push_chan(0, 8, 8, 8, 12, 9, 4'b0000, 4'b0000);
    run_scan(1);

    check("req_queue_empty", 32'(exp_req.size()), 0);
    check("sample_queue_empty", 32'(samp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
